regbank_wb_arbiter: RTL and testbench

Write-back arbiter sharing the single REGBank write port (AddrD/DataD/RegWEn) between two write-back requesters: requester 0 (ALU path) and requester 1 (load path). Each requester has a one-entry holding buffer. A round-robin arbiter with same-address ordering drains one buffer per cycle into a registered write-port stage that drives REGBank directly. The block also drops writes to x0 and exports a pending-write scoreboard for hazard detection in the issue logic.

---
 rtl/regbank_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regbank_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regbank_wb_arbiter: two-requester write-back arbiter feeding the REGBank port
// Revision 1.0
// -----------------------------------------------------------------------------
module regbank_wb_arbiter #(
  parameter int WIDTH_ADDR_LENGTH = 5,
  parameter int WIDTH_DATA_LENGTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req0_valid,
  input  logic [WIDTH_ADDR_LENGTH-1:0]      req0_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0]      req0_data,
  output logic                              req0_ready,
  input  logic                              req1_valid,
  input  logic [WIDTH_ADDR_LENGTH-1:0]      req1_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0]      req1_data,
  output logic                              req1_ready,
  output logic [WIDTH_ADDR_LENGTH-1:0]      AddrD,
  output logic [WIDTH_DATA_LENGTH-1:0]      DataD,
  output logic                              RegWEn,
  output logic [2**WIDTH_ADDR_LENGTH-1:0]   pending
);

  logic                         full0, full1;
  logic                         age0, age1;
  logic [WIDTH_ADDR_LENGTH-1:0] addr0, addr1;
  logic [WIDTH_DATA_LENGTH-1:0] data0, data1;
  logic                         last_grant;

  logic                         grant0, grant1;
  logic                         acc0, acc1;
  logic                         load0, load1;
  logic [WIDTH_ADDR_LENGTH-1:0] grant_addr;
  logic [WIDTH_DATA_LENGTH-1:0] grant_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (full0 && full1) begin
      if (addr0 == addr1) begin
        // Same destination: the older entry drains first so the newest value lands last.
        grant0 = !age0;
        grant1 = age0;
      end else begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end
    end else begin
      grant0 = full0;
      grant1 = full1;
    end
  end

  assign req0_ready = !rst && (!full0 || grant0);
  assign req1_ready = !rst && (!full1 || grant1);

  assign acc0  = req0_valid && req0_ready;
  assign acc1  = req1_valid && req1_ready;
  assign load0 = acc0 && (req0_addr != '0);
  assign load1 = acc1 && (req1_addr != '0);

  assign grant_addr = grant1 ? addr1 : addr0;
  assign grant_data = grant1 ? data1 : data0;

  always_ff @(posedge clk) begin
    if (rst) begin
      full0      <= 1'b0;
      full1      <= 1'b0;
      age0       <= 1'b0;
      age1       <= 1'b0;
      addr0      <= '0;
      addr1      <= '0;
      data0      <= '0;
      data1      <= '0;
      last_grant <= 1'b1;
      RegWEn     <= 1'b0;
      AddrD      <= '0;
      DataD      <= '0;
    end else begin
      RegWEn <= grant0 || grant1;
      if (grant0 || grant1) begin
        AddrD      <= grant_addr;
        DataD      <= grant_data;
        last_grant <= grant1;
      end

      if (load0) begin
        full0 <= 1'b1;
        addr0 <= req0_addr;
        data0 <= req0_data;
        age0  <= full1 && !grant1;
      end else begin
        if (grant0) full0 <= 1'b0;
        if (grant1) age0 <= 1'b0;
      end

      // A same-cycle load of buf0 makes buf1 the younger of the pair.
      if (load1) begin
        full1 <= 1'b1;
        addr1 <= req1_addr;
        data1 <= req1_data;
        age1  <= (full0 && !grant0) || load0;
      end else begin
        if (grant1) full1 <= 1'b0;
        if (grant0) age1 <= 1'b0;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (full0)  pending[addr0] = 1'b1;
    if (full1)  pending[addr1] = 1'b1;
    if (RegWEn) pending[AddrD] = 1'b1;
    pending[0] = 1'b0;
    if (rst) pending = '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for regbank_wb_arbiter: per-cycle vector table plus a write scoreboard.
module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr  = '0;
  logic [31:0] req0_data  = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr  = '0;
  logic [31:0] req1_data  = '0;
  logic        req1_ready;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic        RegWEn;
  logic [31:0] pending;

  always #5 clk = ~clk;

  regbank_wb_arbiter #(.WIDTH_ADDR_LENGTH(5), .WIDTH_DATA_LENGTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn), .pending(pending)
  );

  typedef struct {
    logic        r;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t        tbl[$];
  wr_t         sb[$];
  wr_t         mon_e;
  wr_t         push_e;
  logic [31:0] rf [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic v0, logic [4:0] a0, logic [31:0] d0,
                              logic v1, logic [4:0] a1, logic [31:0] d1,
                              logic e0, logic e1, logic w, logic [4:0] ea,
                              logic [31:0] ed, logic [31:0] ep);
    vec_t t;
    t.r = r; t.v0 = v0; t.a0 = a0; t.d0 = d0; t.v1 = v1; t.a1 = a1; t.d1 = d1;
    t.e_rdy0 = e0; t.e_rdy1 = e1; t.e_wen = w; t.e_addr = ea; t.e_data = ed; t.e_pend = ep;
    return t;
  endfunction

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    push_e.a = a;
    push_e.d = d;
    sb.push_back(push_e);
  endtask

  // REGBank stand-in: every port write is matched against the scoreboard.
  always @(negedge clk) begin
    if (RegWEn === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h want no write", AddrD, DataD);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(AddrD), 32'(mon_e.a));
        chk("wr_data", DataD, mon_e.d);
      end
      rf[AddrD] = DataD;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // reset with both valids high
    tbl.push_back(mk(1, 1, 3, 'h33, 1, 6, 'h66,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 'h33, 1, 6, 'h66,  0, 0, 0, 0, 0, 0));
    // single requester back-to-back
    tbl.push_back(mk(0, 1, 1, 'hA1, 0, 0, 0,     1, 1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 1, 2, 'hA2, 0, 0, 0,     1, 1, 0, 0, 0,     'h2));
    tbl.push_back(mk(0, 1, 3, 'hA3, 0, 0, 0,     1, 1, 1, 1, 'hA1,  'h6));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 2, 'hA2,  'hC));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 3, 'hA3,  'h8));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 3, 'hA3,  0));
    tbl.push_back(mk(1, 0, 0, 0,    0, 0, 0,     0, 0, 0, 3, 'hA3,  0));
    // contention, different addresses
    tbl.push_back(mk(0, 1, 4, 'h10, 1, 5, 'h20,  1, 1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 1, 4, 'h10, 1, 5, 'h20,  1, 0, 0, 0, 0,     'h30));
    tbl.push_back(mk(0, 1, 4, 'h10, 1, 5, 'h20,  0, 1, 1, 4, 'h10,  'h30));
    tbl.push_back(mk(0, 1, 4, 'h10, 1, 5, 'h20,  1, 0, 1, 5, 'h20,  'h30));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     0, 1, 1, 4, 'h10,  'h30));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 5, 'h20,  'h30));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 4, 'h10,  'h10));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 4, 'h10,  0));
    // same address: req1 then req0
    tbl.push_back(mk(0, 0, 0, 0,    1, 7, 'hB,   1, 1, 0, 4, 'h10,  0));
    tbl.push_back(mk(0, 1, 7, 'hC,  0, 0, 0,     1, 1, 0, 4, 'h10,  'h80));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 7, 'hB,   'h80));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 7, 'hC,   'h80));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 7, 'hC,   0));
    // same address loaded together while round-robin favours req1: age must win
    tbl.push_back(mk(0, 1, 7, 'hD0, 1, 7, 'hE0,  1, 1, 0, 7, 'hC,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 0, 0, 7, 'hC,   'h80));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 7, 'hD0,  'h80));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 7, 'hE0,  'h80));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 7, 'hE0,  0));
    // x0 drop, then a normal write
    tbl.push_back(mk(0, 1, 0, 'hFFFF_AAAA, 0, 0, 0, 1, 1, 0, 7, 'hE0, 0));
    tbl.push_back(mk(0, 1, 1, 'h55, 0, 0, 0,     1, 1, 0, 7, 'hE0,  0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 7, 'hE0,  'h2));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 1, 'h55,  'h2));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 1, 'h55,  0));
    // reset with both buffers full
    tbl.push_back(mk(0, 1, 8, 'h88, 1, 9, 'h99,  1, 1, 0, 1, 'h55,  0));
    tbl.push_back(mk(1, 0, 0, 0,    0, 0, 0,     0, 0, 0, 1, 'h55,  0));
    tbl.push_back(mk(0, 1, 10, 'hA0, 1, 11, 'hB0, 1, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 0, 0, 0, 0,     'hC00));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 10, 'hA0, 'hC00));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 1, 11, 'hB0, 'h800));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,     1, 1, 0, 11, 'hB0, 0));

    @(posedge clk);
    foreach (tbl[i]) begin
      #1;
      rst        = tbl[i].r;
      req0_valid = tbl[i].v0;
      req0_addr  = tbl[i].a0;
      req0_data  = tbl[i].d0;
      req1_valid = tbl[i].v1;
      req1_addr  = tbl[i].a1;
      req1_data  = tbl[i].d1;
      if (tbl[i].r) begin
        sb.delete();
      end else begin
        if (tbl[i].v0 && tbl[i].e_rdy0 && tbl[i].a0 != 5'd0) push_wr(tbl[i].a0, tbl[i].d0);
        if (tbl[i].v1 && tbl[i].e_rdy1 && tbl[i].a1 != 5'd0) push_wr(tbl[i].a1, tbl[i].d1);
      end
      @(negedge clk);
      chk($sformatf("v%0d_rdy0", i),  32'(req0_ready), 32'(tbl[i].e_rdy0));
      chk($sformatf("v%0d_rdy1", i),  32'(req1_ready), 32'(tbl[i].e_rdy1));
      chk($sformatf("v%0d_wen", i),   32'(RegWEn),     32'(tbl[i].e_wen));
      chk($sformatf("v%0d_addr", i),  32'(AddrD),      32'(tbl[i].e_addr));
      chk($sformatf("v%0d_data", i),  DataD,           tbl[i].e_data);
      chk($sformatf("v%0d_pend", i),  pending,         tbl[i].e_pend);
      @(posedge clk);
    end

    // req1 streams uncontended back-to-back
    for (int k = 0; k < 3; k++) begin
      #1;
      req1_valid = 1'b1;
      req1_addr  = 5'(20 + k);
      req1_data  = 32'h200 + 32'(16 * k);
      push_wr(req1_addr, req1_data);
      @(negedge clk);
      chk($sformatf("stream_rdy1_%0d", k), 32'(req1_ready), 32'd1);
      @(posedge clk);
    end
    #1 req1_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);

    chk("rf_x7",  rf[7],  32'hE0);
    chk("rf_x0",  rf[0],  32'h0);
    chk("rf_x8",  rf[8],  32'h0);
    chk("rf_x9",  rf[9],  32'h0);
    chk("rf_x22", rf[22], 32'h220);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
